// File: rtl/reg_serial_tx_pkg.sv
// reg_serial_tx_pkg: shared FSM state type and serial line levels for reg_serial_tx.
package reg_serial_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
endpackage

// File: rtl/reg_serial_baud_tick.sv
// reg_serial_baud_tick: per-bit clock divider, ticks on the last clk of every serial bit.
// Ports: clk, reset (async, active-low), clr (hold count at 0), tick (count == CLKS_PER_BIT-1).
module reg_serial_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/reg_serial_tx.sv
// reg_serial_tx: drains a loaded word onto a UART-style serial line, LSB first.
// Ports: clk; reset (async, active-low); din/load (word offered, taken when ready=1);
//        ready (can accept), tx (serial line, idle high), busy (frame in flight).
// Build option: define REG_SERIAL_TX_PARITY_EN to append an even-parity bit after the data.
module reg_serial_tx
  import reg_serial_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0] bit_cnt;
  logic tick, accept, last_bit, line;
`ifdef REG_SERIAL_TX_PARITY_EN
  logic par;
`endif
  // The divider idles at zero, so every frame starts on a fresh bit period.
  reg_serial_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE),
    .tick (tick)
  );
  always_comb begin
    accept = state == IDLE && load && ready;
    last_bit = bit_cnt == BW'(WIDTH - 1);
    state_nx = state;
    case (state)
      IDLE:   state_nx = accept ? START : IDLE;
      START:  state_nx = tick ? DATA : START;
`ifdef REG_SERIAL_TX_PARITY_EN
      DATA:   state_nx = (tick && last_bit) ? PARITY : DATA;
      PARITY: state_nx = tick ? STOP : PARITY;
`else
      DATA:   state_nx = (tick && last_bit) ? STOP : DATA;
`endif
      STOP:   state_nx = tick ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
`ifdef REG_SERIAL_TX_PARITY_EN
    line = state == START ? LINE_START : state == DATA ? shift[0] : state == PARITY ? par : LINE_IDLE;
`else
    line = state == START ? LINE_START : state == DATA ? shift[0] : LINE_IDLE;
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // tx is registered from the current state, so the line trails the FSM by one
  // clock: the start bit appears on the edge after acceptance and the stop bit is
  // still on the line during the first IDLE cycle, leaving exactly one idle-high
  // cycle between back-to-back frames.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      shift <= '0;
      bit_cnt <= '0;
      tx <= LINE_IDLE;
      ready <= 1'b1;
      busy <= 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      tx <= line;
      ready <= state_nx == IDLE;
      busy <= state_nx != IDLE;
      if (accept) begin
        shift <= din;
        bit_cnt <= '0;
`ifdef REG_SERIAL_TX_PARITY_EN
        par <= ^din;
`endif
      end else if (state == DATA && tick) begin
        shift <= shift >> 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end
    end
endmodule

// File: tb/tb_reg_serial_tx.sv
// tb_reg_serial_tx: scoreboard bench; a frame-level model queues the expected line per cycle.
module tb_reg_serial_tx;
  localparam int W = 8;
  localparam int CPB = 4;
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = W + 2 + P;
  localparam int FRAME = NB * CPB;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] din;
  logic load;
  logic ready, tx, busy;

  int checks = 0;
  int errors = 0;
  logic line_q[$];
  int left = 0;

  reg_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .load (load),
    .ready(ready),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an accepted word becomes a list of line levels, one per clock.
  // The leading 1 is the acceptance cycle itself, still idle on the line.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      line_q.delete();
      left = 0;
    end else if (load && left == 0) begin
      line_q.push_back(1'b1);
      for (int i = 0; i < NB; i++) begin
        logic b;
        b = (i == 0) ? 1'b0 : (i <= W) ? din[i-1] : (P == 1 && i == W + 1) ? ^din : 1'b1;
        repeat (CPB) line_q.push_back(b);
      end
      left = FRAME;
    end else if (left > 0) begin
      left--;
    end
  end

  // Monitor: consumes one expected line level per cycle, idle high when nothing is queued.
  always @(negedge clk) begin
    logic e;
    e = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
    chk("tx", {31'b0, tx}, {31'b0, e});
    chk("ready", {31'b0, ready}, {31'b0, left == 0});
    chk("busy", {31'b0, busy}, {31'b0, left != 0});
  end

  task automatic drive(input logic l, input logic [W-1:0] d);
    @(posedge clk);
    #2;
    load = l;
    din = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, W'($urandom));
  endtask

  task automatic abort_now();
    reset = 1'b0;
    #1;
    chk("abort_tx", {31'b0, tx}, 32'd1);
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    load = 1'b0;
    din = '0;
    #12;
    reset = 1'b1;
    #1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    idle(20);
    // single word
    drive(1'b1, 8'h0A);
    idle(FRAME + 4);
    // load held during a frame: only the second word after the stop bit
    drive(1'b1, 8'h03);
    drive(1'b1, 8'hFF);
    repeat (FRAME) drive(1'b1, 8'hFF);
    idle(FRAME + 4);
    // reset during data bit 3, then a clean frame
    drive(1'b1, 8'h0A);
    drive(1'b0, 8'h00);
    repeat (17) @(posedge clk);
    #3;
    abort_now();
    drive(1'b1, 8'h03);
    idle(FRAME + 4);
    // reset while the start bit (low) is on the line
    drive(1'b1, W'($urandom));
    drive(1'b0, 8'h00);
    @(posedge clk);
    #3;
    abort_now();
    idle(3);
    // parity-sensitive words
    drive(1'b1, 8'h0A);
    idle(FRAME + 4);
    drive(1'b1, 8'h0B);
    idle(FRAME + 4);
    // continuous load: frames separated by one idle cycle
    repeat (3 * (FRAME + 1)) drive(1'b1, 8'h55);
    idle(FRAME + 4);
    // random words and load pulses, including loads while busy
    repeat (800) drive($urandom_range(0, 3) == 0, W'($urandom));
    idle(FRAME + 4);
    chk("drain", line_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_serial_tx.md
Name: reg_serial_tx

Overview:
- Parallel-to-serial transmitter that drains an 8-bit register word onto a single-wire serial line.
- It is the read-out counterpart of the team's loadable 8-bit register. The register captures `din` on `load`; this block accepts a word with the same `din`/`load` pair and shifts it out LSB-first in UART-style framing.
- It sits between a register or producer and an off-block serial link.

Parameters:
- WIDTH, 8, data word width in bits.
- CLKS_PER_BIT, 4, clk cycles per serial bit. Legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- din  input  WIDTH  parallel word to transmit.
- load  input  1  request: din is valid this cycle.
- ready  output  1  1 when a word can be accepted; transfer occurs on a rising edge with load=1 and ready=1.
- tx  output  1  serial line, idle high.
- busy  output  1  1 while a frame is on the line.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, ready=1, busy=0.
  - Shift register, bit counter and baud counter are all 0.
- States:
  - IDLE: tx=1, ready=1, busy=0. On load & ready, capture din into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After WIDTH bits go to PARITY if enabled, otherwise STOP.
  - PARITY (optional): tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - tx falls on the first rising edge after the accepting edge.
  - The frame is (1 + WIDTH + P + 1) × CLKS_PER_BIT cycles long, where P = 1 with parity and 0 without.
  - ready and busy are registered outputs.
  - ready=0 from the cycle after acceptance until the state returns to IDLE. busy is the complement of ready.
- Boundary conditions:
  - load while ready=0: ignored, with no effect on the frame in flight. din changing mid-frame has no effect, because the word is captured at acceptance.
  - Back-to-back frames: ready returns 1 in the first IDLE cycle. A load held high is accepted there, so the minimum gap between stop bit and next start bit is 1 idle cycle.
  - reset asserted mid-frame: the frame is aborted and tx goes to 1 immediately (asynchronous). After reset releases, there is no partial-frame resume.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Its width is $clog2(CLKS_PER_BIT).
  - Bit counter width is $clog2(WIDTH+1).
- Outputs are driven only from registers; there is no combinational path from din or load to tx.

Optional Feature:
- Macro: REG_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA carrying even parity, i.e. the XOR of the captured word. The frame is WIDTH+3 bits long.
- Undefined: the PARITY state and parity logic are absent, DATA goes directly to STOP, and the frame is WIDTH+2 bits long.

Decomposition:
- Package reg_serial_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the idle-line level constant (1'b1);
  - the start-bit level constant (1'b0).
- One sub-module, reg_serial_baud_tick, is natural. It is the CLKS_PER_BIT counter with a clear input and a one-cycle tick output at the last count of each bit, sharing the same clk/reset.

Test Plan (WIDTH=8, CLKS_PER_BIT=4):
1. Reset held low 10 ns then released -> tx=1, ready=1, busy=0; outputs remain unchanged for 200 ns with load=0.
2. din=8'h0A, load=1 for one cycle (no parity) -> tx=0 for 4 cycles, then data bits 0,1,0,1,0,0,0,0 at 4 cycles each, then stop=1 for 4 cycles; ready returns 1 at cycle 41 after acceptance.
3. din=8'h03 accepted, then load=1 with din=8'hFF held during the frame -> only the 0x03 frame appears (bits 1,1,0,0,0,0,0,0); 0xFF is accepted in the first IDLE cycle after stop and sent next.
4. Accept 8'h0A, assert reset=0 during data bit 3 -> tx=1, ready=1, busy=0 immediately; after release, load of 8'h03 sends a clean complete frame.
5. With REG_SERIAL_TX_PARITY_EN defined: din=8'h0A -> parity bit 0 after the data bits; din=8'h0B -> parity bit 1; frame length 44 cycles.
6. load held high continuously with din=8'h55 -> consecutive frames separated by exactly 1 idle-high cycle; busy deasserts only for that single cycle.
